icache_refill: RTL and testbench

Refill engine for the VLIW instruction cache. When the cache reports a miss on the current pack address, it fetches the 128-bit instruction pack as four 32-bit Wishbone classic reads. It then presents the pack to the cache's `new_entry`/`entry_valid` write port for exactly one cycle. It aborts cleanly on branch-away or cache invalidation, and reports bus errors and timeouts as a fetch fault.

---
 rtl/icache_refill_pkg.sv | 22 ++
 rtl/icache_refill_if.sv | 29 ++
 rtl/icache_refill.sv | 116 +++++++++++
 tb/tb_icache_refill.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/icache_refill_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | icache_refill_pkg : shared VLIW fetch types and sizing constants  |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
package icache_refill_pkg;

    localparam int PACK_BEATS = 4;
    localparam int PACK_W     = 128;
    localparam int PC_W       = 28;
    localparam int WORD_W     = 32;
    localparam int BEAT_W     = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUS   = 2'd1,
        S_WRITE = 2'd2,
        S_FAULT = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/icache_refill_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | icache_refill_if : Wishbone classic read port for pack refills    |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
interface icache_refill_if;
    import icache_refill_pkg::*;

    logic              wb_cyc_o;
    logic              wb_stb_o;
    logic              wb_we_o;
    logic [3:0]        wb_sel_o;
    logic [WORD_W-1:0] wb_adr_o;
    logic [WORD_W-1:0] wb_dat_i;
    logic              wb_ack_i;
    logic              wb_err_i;

    modport master (
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o,
        input  wb_dat_i, wb_ack_i, wb_err_i
    );

    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o,
        output wb_dat_i, wb_ack_i, wb_err_i
    );

endinterface
`default_nettype wire

// File: rtl/icache_refill.sv
`default_nettype none
// +------------------------------------------------------------------+
// | icache_refill : fetches a 128-bit pack as four Wishbone reads and |
// | writes it into the instruction cache. Revision: 1.0               |
// +------------------------------------------------------------------+
module icache_refill
    import icache_refill_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic              wb_clk_i,
    input  logic              rst,
    input  logic [PC_W-1:0]   curr_PC,
    input  logic              cache_hit,
    input  logic              invalidate,
    output logic [PACK_W-1:0] new_entry,
    output logic              entry_valid,
    output logic              busy,
    output logic              fetch_fault,
    icache_refill_if.master   wb
);

    localparam logic [7:0] C_TIMEOUT = 8'(TIMEOUT);

    state_t            state_q;
    logic [PC_W-1:0]   pc_q;
    logic [BEAT_W-1:0] beat_q;
    logic [7:0]        tmo_q;
    logic [WORD_W-1:0] bank_q [PACK_BEATS];
    logic              cyc_q;
    logic              valid_q;

    logic              w_pc_match;
    logic [7:0]        w_tmo_next;
    logic              w_tmo_hit;

    assign w_pc_match = (curr_PC == pc_q);
    assign w_tmo_next = (tmo_q == 8'hFF) ? tmo_q : tmo_q + 8'd1;
    assign w_tmo_hit  = (w_tmo_next >= C_TIMEOUT);

    always_ff @(posedge wb_clk_i) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            beat_q  <= '0;
            tmo_q   <= '0;
            cyc_q   <= 1'b0;
            valid_q <= 1'b0;
            for (int i = 0; i < PACK_BEATS; i++) begin
                bank_q[i] <= '0;
            end
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!cache_hit && !invalidate) begin
                        pc_q    <= curr_PC;
                        beat_q  <= '0;
                        tmo_q   <= '0;
                        cyc_q   <= 1'b1;
                        state_q <= S_BUS;
                    end
                end
                S_BUS: begin
                    // Abort outranks any same-cycle response; ack outranks timeout.
                    if (invalidate || !w_pc_match) begin
                        cyc_q   <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (wb.wb_err_i) begin
                        cyc_q   <= 1'b0;
                        state_q <= S_FAULT;
                    end else if (wb.wb_ack_i) begin
                        bank_q[beat_q] <= wb.wb_dat_i;
                        beat_q         <= beat_q + 2'd1;
                        tmo_q          <= '0;
                        if (beat_q == 2'd3) begin
                            cyc_q   <= 1'b0;
                            valid_q <= 1'b1;
                            state_q <= S_WRITE;
                        end
                    end else if (w_tmo_hit) begin
                        cyc_q   <= 1'b0;
                        state_q <= S_FAULT;
                    end else begin
                        tmo_q <= w_tmo_next;
                    end
                end
                S_WRITE: begin
                    state_q <= S_IDLE;
                end
                S_FAULT: begin
                    if (invalidate || !w_pc_match) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // The cache tags with the live PC, so a late mismatch must squash the write.
    assign entry_valid = valid_q && !invalidate && w_pc_match;
    assign new_entry   = {bank_q[3], bank_q[2], bank_q[1], bank_q[0]};
    assign busy        = (state_q != S_IDLE);
    assign fetch_fault = (state_q == S_FAULT);

    assign wb.wb_cyc_o = cyc_q;
    assign wb.wb_stb_o = cyc_q;
    assign wb.wb_we_o  = 1'b0;
    assign wb.wb_sel_o = 4'hF;
    assign wb.wb_adr_o = {pc_q, beat_q, 2'b00};

endmodule
`default_nettype wire

// File: tb/tb_icache_refill.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_icache_refill : directed self-checking bench for icache_refill |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module tb_icache_refill;

    logic         clk = 1'b0;
    logic         rst;
    logic [27:0]  curr_PC;
    logic         cache_hit;
    logic         invalidate;
    logic [127:0] new_entry;
    logic         entry_valid;
    logic         busy;
    logic         fetch_fault;

    icache_refill_if wbus();

    icache_refill #(.TIMEOUT(4)) dut (
        .wb_clk_i    (clk),
        .rst         (rst),
        .curr_PC     (curr_PC),
        .cache_hit   (cache_hit),
        .invalidate  (invalidate),
        .new_entry   (new_entry),
        .entry_valid (entry_valid),
        .busy        (busy),
        .fetch_fault (fetch_fault),
        .wb          (wbus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Slave model: answers after wait_cfg wait cycles, optionally err on one beat.
    int          wait_cfg = 0;
    int          err_beat = -1;
    bit          never_ack = 1'b0;
    int          wcnt = 0;
    logic [31:0] words [4];

    always @(negedge clk) begin
        wbus.wb_ack_i = 1'b0;
        wbus.wb_err_i = 1'b0;
        wbus.wb_dat_i = 32'h0;
        if (wbus.wb_cyc_o && wbus.wb_stb_o && !never_ack) begin
            if (wcnt == wait_cfg) begin
                if (int'(wbus.wb_adr_o[3:2]) == err_beat) wbus.wb_err_i = 1'b1;
                else wbus.wb_ack_i = 1'b1;
                wbus.wb_dat_i = words[wbus.wb_adr_o[3:2]];
                wcnt = 0;
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired got running exp finished");
        $fatal(1, "watchdog");
    end

    task automatic cycle;
        @(posedge clk);
        #1;
    endtask

    int          ev_cyc;
    int          ev_cnt;
    int          cyc_falls;
    logic [31:0] adr_q [$];

    // Observes n cycles starting with the current one; emulates the cache
    // reporting a hit once the entry is written.
    task automatic watch(input int n);
        logic        prev_cyc;
        logic [31:0] prev_adr;
        prev_cyc = 1'b0;
        prev_adr = '1;
        ev_cyc = 0; ev_cnt = 0; cyc_falls = 0;
        adr_q.delete();
        for (int c = 1; c <= n; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            #1;
            if (entry_valid) begin
                ev_cnt++;
                if (ev_cyc == 0) ev_cyc = c;
                cache_hit = 1'b1;
            end
            if (wbus.wb_cyc_o && (!prev_cyc || wbus.wb_adr_o != prev_adr)) adr_q.push_back(wbus.wb_adr_o);
            if (prev_cyc && !wbus.wb_cyc_o) cyc_falls++;
            prev_cyc = wbus.wb_cyc_o;
            prev_adr = wbus.wb_adr_o;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; curr_PC = '0; cache_hit = 1'b1; invalidate = 1'b0;
        cycle(); cycle(); #1;
        checks++; if (wbus.wb_cyc_o !== 1'b0) begin errors++; $display("FAIL reset_cyc got %0h exp 0", wbus.wb_cyc_o); end
        checks++; if (wbus.wb_stb_o !== 1'b0) begin errors++; $display("FAIL reset_stb got %0h exp 0", wbus.wb_stb_o); end
        checks++; if (wbus.wb_we_o !== 1'b0) begin errors++; $display("FAIL reset_we got %0h exp 0", wbus.wb_we_o); end
        checks++; if (wbus.wb_sel_o !== 4'hF) begin errors++; $display("FAIL reset_sel got %0h exp f", wbus.wb_sel_o); end
        checks++; if (wbus.wb_adr_o !== 32'h0) begin errors++; $display("FAIL reset_adr got %0h exp 0", wbus.wb_adr_o); end
        checks++; if ({entry_valid, busy, fetch_fault} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {entry_valid, busy, fetch_fault}); end
        checks++; if (new_entry !== 128'h0) begin errors++; $display("FAIL reset_entry got %h exp 0", new_entry); end
        rst = 1'b0;
    endtask

    task automatic test_basic;
        cycle();
        wait_cfg = 0; err_beat = -1; never_ack = 1'b0;
        words[0] = 32'h11111111; words[1] = 32'h22222222; words[2] = 32'h33333333; words[3] = 32'h44444444;
        curr_PC = 28'h0000010; cache_hit = 1'b0;
        watch(10);
        checks++; if (ev_cyc !== 6) begin errors++; $display("FAIL basic_latency got %0d exp 6", ev_cyc); end
        checks++; if (ev_cnt !== 1) begin errors++; $display("FAIL basic_ev_count got %0d exp 1", ev_cnt); end
        checks++; if (adr_q.size() !== 4) begin errors++; $display("FAIL basic_beats got %0d exp 4", adr_q.size()); end
        for (int i = 0; i < 4 && i < adr_q.size(); i++) begin
            checks++; if (adr_q[i] !== 32'h100 + 32'(4 * i)) begin errors++; $display("FAIL basic_adr%0d got %h exp %h", i, adr_q[i], 32'h100 + 32'(4 * i)); end
        end
        checks++; if (new_entry !== 128'h44444444_33333333_22222222_11111111) begin errors++; $display("FAIL basic_entry got %h exp 44444444333333332222222211111111", new_entry); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle_after got %0h exp 0", busy); end
    endtask

    task automatic test_wait_states;
        cycle();
        wait_cfg = 3;
        words[0] = 32'hA1A1A1A1; words[1] = 32'hB2B2B2B2; words[2] = 32'hC3C3C3C3; words[3] = 32'hD4D4D4D4;
        curr_PC = 28'h0000020; cache_hit = 1'b0;
        watch(24);
        checks++; if (ev_cyc !== 18) begin errors++; $display("FAIL wait_latency got %0d exp 18", ev_cyc); end
        checks++; if (cyc_falls !== 1) begin errors++; $display("FAIL wait_cyc_drops got %0d exp 1", cyc_falls); end
        checks++; if (adr_q.size() !== 4 || adr_q[0] !== 32'h200) begin errors++; $display("FAIL wait_adr got n=%0d first=%h exp n=4 first=200", adr_q.size(), adr_q[0]); end
        checks++; if (new_entry !== 128'hD4D4D4D4_C3C3C3C3_B2B2B2B2_A1A1A1A1) begin errors++; $display("FAIL wait_entry got %h exp d4d4d4d4c3c3c3c3b2b2b2b2a1a1a1a1", new_entry); end
        wait_cfg = 0;
    endtask

    task automatic test_branch_away;
        cycle();
        words[0] = 32'h11111111; words[1] = 32'h22222222; words[2] = 32'h33333333; words[3] = 32'h44444444;
        curr_PC = 28'h0000010; cache_hit = 1'b0;
        cycle(); cycle(); #1;
        checks++; if (wbus.wb_adr_o !== 32'h104) begin errors++; $display("FAIL branch_beat1_adr got %h exp 104", wbus.wb_adr_o); end
        cycle();
        curr_PC = 28'h0000020; #1;
        checks++; if (entry_valid !== 1'b0) begin errors++; $display("FAIL branch_no_write got %0h exp 0", entry_valid); end
        cycle(); #1;
        checks++; if ({wbus.wb_cyc_o, busy} !== 2'b00) begin errors++; $display("FAIL branch_cyc_drop got %b exp 00", {wbus.wb_cyc_o, busy}); end
        cycle(); #1;
        checks++; if (wbus.wb_cyc_o !== 1'b1 || wbus.wb_adr_o !== 32'h200) begin errors++; $display("FAIL branch_restart got cyc=%0h adr=%h exp cyc=1 adr=200", wbus.wb_cyc_o, wbus.wb_adr_o); end
        watch(8);
        checks++; if (ev_cyc !== 5 || ev_cnt !== 1) begin errors++; $display("FAIL branch_refill got cyc=%0d n=%0d exp cyc=5 n=1", ev_cyc, ev_cnt); end
    endtask

    task automatic test_late_abort;
        cycle();
        curr_PC = 28'h0000030; cache_hit = 1'b0;
        cycle(); cycle(); cycle(); cycle(); cycle();
        curr_PC = 28'h0000031; cache_hit = 1'b1; #1;
        checks++; if (entry_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL late_abort got ev=%0h busy=%0h exp ev=0 busy=1", entry_valid, busy); end
        cycle(); cycle(); #1;
        checks++; if (wbus.wb_cyc_o !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL late_abort_idle got cyc=%0h busy=%0h exp 0 0", wbus.wb_cyc_o, busy); end
        // invalidate while waiting on a slow beat
        wait_cfg = 2;
        curr_PC = 28'h0000040; cache_hit = 1'b0;
        cycle(); cycle();
        invalidate = 1'b1; cache_hit = 1'b1; #1;
        checks++; if (entry_valid !== 1'b0) begin errors++; $display("FAIL inval_no_write got %0h exp 0", entry_valid); end
        cycle(); #1;
        checks++; if (wbus.wb_cyc_o !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL inval_idle got cyc=%0h busy=%0h exp 0 0", wbus.wb_cyc_o, busy); end
        invalidate = 1'b0; wait_cfg = 0;
    endtask

    task automatic test_bus_error;
        cycle();
        err_beat = 2;
        curr_PC = 28'h0000050; cache_hit = 1'b0;
        cycle(); cycle(); cycle(); cycle(); #1;
        checks++; if (fetch_fault !== 1'b1 || wbus.wb_cyc_o !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL err_fault got ff=%0h cyc=%0h busy=%0h exp 1 0 1", fetch_fault, wbus.wb_cyc_o, busy); end
        cycle(); #1;
        checks++; if (fetch_fault !== 1'b1 || wbus.wb_cyc_o !== 1'b0) begin errors++; $display("FAIL err_hold got ff=%0h cyc=%0h exp 1 0", fetch_fault, wbus.wb_cyc_o); end
        cycle();
        err_beat = -1; curr_PC = 28'h0000051;
        cycle(); #1;
        checks++; if (fetch_fault !== 1'b0 || wbus.wb_cyc_o !== 1'b0) begin errors++; $display("FAIL err_clear got ff=%0h cyc=%0h exp 0 0", fetch_fault, wbus.wb_cyc_o); end
        cycle(); #1;
        checks++; if (wbus.wb_cyc_o !== 1'b1 || wbus.wb_adr_o !== 32'h510) begin errors++; $display("FAIL err_restart got cyc=%0h adr=%h exp cyc=1 adr=510", wbus.wb_cyc_o, wbus.wb_adr_o); end
        watch(8);
        checks++; if (ev_cyc !== 5) begin errors++; $display("FAIL err_refill got %0d exp 5", ev_cyc); end
    endtask

    task automatic test_timeout_reset;
        cycle();
        never_ack = 1'b1;
        curr_PC = 28'h0000060; cache_hit = 1'b0;
        cycle(); cycle(); cycle(); cycle(); #1;
        checks++; if (wbus.wb_cyc_o !== 1'b1 || fetch_fault !== 1'b0) begin errors++; $display("FAIL tmo_bus4 got cyc=%0h ff=%0h exp 1 0", wbus.wb_cyc_o, fetch_fault); end
        cycle(); #1;
        checks++; if (fetch_fault !== 1'b1 || wbus.wb_cyc_o !== 1'b0) begin errors++; $display("FAIL tmo_fault got ff=%0h cyc=%0h exp 1 0", fetch_fault, wbus.wb_cyc_o); end
        invalidate = 1'b1; cache_hit = 1'b1;
        cycle(); #1;
        checks++; if (fetch_fault !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL tmo_exit got ff=%0h busy=%0h exp 0 0", fetch_fault, busy); end
        invalidate = 1'b0; never_ack = 1'b0;
        // reset in the middle of a slow refill
        wait_cfg = 3;
        curr_PC = 28'h0000070; cache_hit = 1'b0;
        cycle(); cycle();
        rst = 1'b1;
        cycle(); #1;
        checks++; if ({wbus.wb_cyc_o, wbus.wb_stb_o, entry_valid, busy, fetch_fault} !== 5'b0) begin errors++; $display("FAIL rst_flags got %b exp 00000", {wbus.wb_cyc_o, wbus.wb_stb_o, entry_valid, busy, fetch_fault}); end
        checks++; if (wbus.wb_adr_o !== 32'h0 || wbus.wb_sel_o !== 4'hF) begin errors++; $display("FAIL rst_bus got adr=%h sel=%h exp 0 f", wbus.wb_adr_o, wbus.wb_sel_o); end
        checks++; if (new_entry !== 128'h0) begin errors++; $display("FAIL rst_entry got %h exp 0", new_entry); end
        rst = 1'b0; cache_hit = 1'b1; wait_cfg = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wait_states();
        test_branch_away();
        test_late_abort();
        test_bus_error();
        test_timeout_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
